// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a slow clock in the iclk domain,
// checks each period against a window, and reports lock, stuck and sticky errors.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int PER_MIN  = 3,
  parameter int PER_MAX  = 3,
  parameter int TIMEOUT  = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             iclk,
  input  logic             rstn,
  input  logic             clk_mon,
  input  logic             enable,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             lock,
  output logic             stuck,
  output logic             err_sticky
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_EDGE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;
  localparam logic [1:0] LOCKED    = 2'd3;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int GD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(PER_MIN);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(PER_MAX);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [GD_W-1:0]  GOOD_LAST = GD_W'(LOCK_CNT - 1);

  logic [2:0]       r_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic             r_fall_seen;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GD_W-1:0]  r_good;
  logic             w_rise;
  logic             w_fall;
  logic             w_run;
  logic             w_good;
  logic             w_bad;

  assign w_rise = r_sync[1] & ~r_sync[2];
  assign w_fall = ~r_sync[1] & r_sync[2];
  assign w_run  = (r_state == MEASURE) || (r_state == LOCKED);
  assign w_good = (r_per_cnt >= MIN_C) && (r_per_cnt <= MAX_C);
  assign w_bad  = enable & w_run & w_rise & ~w_good;

  always_ff @(posedge iclk or negedge rstn)
    if (!rstn) r_sync <= '0;
    else r_sync <= {r_sync[1:0], clk_mon};

  always_ff @(posedge iclk or negedge rstn)
    if (!rstn) begin
      r_state     <= IDLE;
      r_per_cnt   <= '0;
      r_high_cnt  <= '0;
      r_fall_seen <= 1'b0;
      r_to_cnt    <= '0;
      r_good      <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      lock        <= 1'b0;
      stuck       <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err_sticky <= w_bad | (err_sticky & ~clr_err);
      if (!enable) begin
        r_state     <= IDLE;
        r_per_cnt   <= '0;
        r_high_cnt  <= '0;
        r_fall_seen <= 1'b0;
        r_to_cnt    <= '0;
        r_good      <= '0;
        lock        <= 1'b0;
        stuck       <= 1'b0;
      end else if (r_state == IDLE) begin
        r_state <= WAIT_EDGE;
      end else if (w_rise) begin
        // every rise restarts the counters; only a rise while running closes a period
        r_per_cnt   <= CNT_W'(1);
        r_high_cnt  <= CNT_W'(1);
        r_fall_seen <= 1'b0;
        r_to_cnt    <= '0;
        stuck       <= 1'b0;
        if (!w_run) begin
          r_state <= MEASURE;
        end else begin
          period     <= r_per_cnt;
          high_time  <= r_high_cnt;
          meas_valid <= 1'b1;
          if (!w_good) begin
            r_state <= MEASURE;
            lock    <= 1'b0;
            r_good  <= '0;
          end else if (r_state == MEASURE) begin
            r_good <= r_good + 1'b1;
            if (r_good == GOOD_LAST) begin
              r_state <= LOCKED;
              lock    <= 1'b1;
            end
          end
        end
      end else if (w_run) begin
        r_per_cnt   <= (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + 1'b1;
        r_high_cnt  <= (r_fall_seen | w_fall | (r_high_cnt == CNT_MAX)) ? r_high_cnt : r_high_cnt + 1'b1;
        r_fall_seen <= r_fall_seen | w_fall;
        if (r_to_cnt == TO_LAST) begin
          r_state <= WAIT_EDGE;
          stuck   <= 1'b1;
          lock    <= 1'b0;
          r_good  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: random and directed clk_mon patterns checked every cycle against
// a time-stamp reference model (edges seen two iclk edges after they are sampled).
module tb_clk_div_monitor;
  localparam int PER_MIN  = 3;
  localparam int PER_MAX  = 3;
  localparam int TIMEOUT  = 16;
  localparam int LOCK_CNT = 4;

  logic       iclk = 1'b0;
  logic       rstn = 1'b0;
  logic       clk_mon = 1'b0;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] period, high_time, s_period, s_high_time;
  logic       meas_valid, lock, stuck, err_sticky;
  logic       s_meas_valid, s_lock, s_stuck, s_err_sticky;

  int n_chk = 0;
  int n_pass = 0;

  int         q_due[$];
  logic       q_val[$];
  int         e = 0;
  int         m_st, m_good, t_rise, t_fall;
  logic [7:0] m_per, m_ht;
  logic       m_mv, m_lock, m_stuck, m_err, m_last;

  always #5 iclk = ~iclk;

  clk_div_monitor u_dut (
    .iclk(iclk), .rstn(rstn), .clk_mon(clk_mon), .enable(enable), .clr_err(clr_err),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .lock(lock), .stuck(stuck), .err_sticky(err_sticky)
  );

  // long timeout so a 300-cycle period is measured rather than declared stuck
  clk_div_monitor #(.TIMEOUT(512)) u_sat (
    .iclk(iclk), .rstn(rstn), .clk_mon(clk_mon), .enable(enable), .clr_err(clr_err),
    .period(s_period), .high_time(s_high_time), .meas_valid(s_meas_valid),
    .lock(s_lock), .stuck(s_stuck), .err_sticky(s_err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask

  task automatic m_reset();
    q_due.delete(); q_val.delete();
    m_st = 0; m_good = 0; t_rise = 0; t_fall = -1; m_last = 1'b0;
    m_per = '0; m_ht = '0; m_mv = 1'b0; m_lock = 1'b0; m_stuck = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic rise_due();
    return q_due.size() > 0 && q_due[0] == e && q_val[0];
  endfunction

  task automatic m_step(input logic v, input logic en, input logic clr);
    logic rise, fall, set;
    int p, h;
    rise = 1'b0; fall = 1'b0; set = 1'b0;
    if (q_due.size() > 0 && q_due[0] == e) begin
      rise = q_val[0]; fall = ~q_val[0];
      void'(q_due.pop_front()); void'(q_val.pop_front());
    end
    if (v != m_last) begin q_due.push_back(e + 2); q_val.push_back(v); m_last = v; end
    m_mv = 1'b0;
    if (!en) begin
      m_st = 0; m_lock = 1'b0; m_stuck = 1'b0; m_good = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (rise) begin m_st = 2; t_rise = e; t_fall = -1; m_stuck = 1'b0; end
    end else begin
      if (fall && t_fall < 0) t_fall = e;
      if (rise) begin
        p = e - t_rise; if (p > 255) p = 255;
        h = (t_fall >= 0) ? t_fall - t_rise : p; if (h > 255) h = 255;
        m_per = p[7:0]; m_ht = h[7:0]; m_mv = 1'b1;
        if (p >= PER_MIN && p <= PER_MAX) begin
          m_good++;
          if (m_good >= LOCK_CNT) m_lock = 1'b1;
        end else begin
          m_good = 0; m_lock = 1'b0; set = 1'b1;
        end
        t_rise = e; t_fall = -1; m_stuck = 1'b0;
      end else if (e - t_rise == TIMEOUT) begin
        m_st = 1; m_stuck = 1'b1; m_lock = 1'b0; m_good = 0;
      end
    end
    m_err = set | (m_err & ~clr);
    e++;
  endtask

  task automatic cyc(input logic v, input logic en, input logic clr);
    clk_mon = v; enable = en; clr_err = clr;
    @(posedge iclk);
    m_step(v, en, clr);
    @(negedge iclk);
    chk("outs", 32'({period, high_time, meas_valid, lock, stuck, err_sticky}),
        32'({m_per, m_ht, m_mv, m_lock, m_stuck, m_err}));
  endtask

  task automatic per(input int len, input int hi);
    for (int j = 0; j < len; j++) cyc(j < hi, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #1;
    m_reset();
    chk("async_rst", 32'({period, high_time, meas_valid, lock, stuck, err_sticky}), 32'd0);
    @(posedge iclk);
    @(negedge iclk);
    rstn = 1'b1;
  endtask

  initial begin
    int len, hi, n;
    logic got;
    m_reset();
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    chk("reset", 32'({period, high_time, meas_valid, lock, stuck, err_sticky}), 32'd0);
    rstn = 1'b1;
    repeat (12) per(3, 1);
    chk("locked_div3", 32'(lock), 32'd1);
    repeat (30) cyc(1'b0, 1'b1, 1'b0);
    chk("stuck_low", 32'(stuck), 32'd1);
    repeat (10) per(3, 2);
    per(5, 2);
    repeat (2) per(3, 1);
    cyc(1'b1, 1'b1, 1'b1);
    per(3, 1);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 5; j++) cyc(j < 2, 1'b1, rise_due());
    repeat (6) per(3, 1);
    per(16, 4);
    repeat (6) per(3, 1);
    per(17, 4);
    repeat (6) per(3, 2);
    for (int j = 0; j < 8; j++) cyc(j % 3 == 0, j > 3, 1'b0);
    repeat (300) begin
      len = ($urandom_range(0, 2) != 0) ? 3 : $urandom_range(2, 7);
      hi  = $urandom_range(1, len - 1);
      n   = $urandom_range(0, 19);
      if ($urandom_range(0, 24) == 0) repeat ($urandom_range(14, 20)) cyc(1'b0, 1'b1, 1'b0);
      for (int j = 0; j < len; j++) cyc(j < hi, !(n == 0 && j < 2), $urandom_range(0, 9) == 0);
    end
    repeat (10) per(3, 1);
    pulse_reset();
    repeat (8) per(3, 1);
    pulse_reset();
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    repeat (300) cyc(1'b1, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (s_meas_valid) begin
        got = 1'b1;
        chk("sat_period", 32'(s_period), 32'd255);
        chk("sat_high", 32'(s_high_time), 32'd255);
      end
    end
    chk("sat_seen", 32'(got), 32'd1);
    repeat (4) per(3, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
